// File: rtl/mul_flag_collect.sv
// ============================================================================
// mul_flag_collect: sticky IEEE fflags accumulator plus trap-record FIFO.
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_flag_collect #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_vld,
  output logic                     st_rdy,
  input  logic [4:0]               status,
  input  logic [TAG_W-1:0]         st_tag,
  input  logic                     csr_wr,
  input  logic [4:0]               csr_wdata,
  input  logic                     csr_clr,
  input  logic [4:0]               trap_en,
  output logic [4:0]               fflags,
  output logic                     trap_vld,
  input  logic                     trap_rdy,
  output logic [TAG_W-1:0]         trap_tag,
  output logic [4:0]               trap_flags,
  output logic [$clog2(DEPTH):0]   trap_cnt,
  output logic                     trap_lost
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        r_fflags;
  logic              r_vld;
  logic [TAG_W-1:0]  r_tag;
  logic [4:0]        r_flags;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_lost;
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [TAG_W-1:0]  r_mem_tag   [DEPTH];
  logic [4:0]        r_mem_flags [DEPTH];

  logic [4:0]        w_acc;
  logic [4:0]        w_tflags;
  logic              w_push_req;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic [4:0]        w_fflags_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [PTR_W-1:0]  w_wr_nxt;
  logic [TAG_W-1:0]  w_head_tag;
  logic [4:0]        w_head_flags;

  assign st_rdy = 1'b1;

  always_comb begin
    w_acc        = st_vld ? status : 5'b00000;
    w_tflags     = status & trap_en;
    w_push_req   = st_vld && (w_tflags != 5'b00000);
    w_pop        = r_vld && trap_rdy;
    w_full       = (r_cnt == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    w_push       = w_push_req && (!w_full || w_pop);
    w_drop       = w_push_req && w_full && !w_pop;

    if (csr_wr)
      w_fflags_nxt = csr_wdata | w_acc;
    else if (csr_clr)
      w_fflags_nxt = w_acc;
    else
      w_fflags_nxt = r_fflags | w_acc;

    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (!w_push && w_pop)
      w_cnt_nxt = r_cnt - CNT_W'(1);

    w_rd_nxt = w_pop  ? r_rd + PTR_W'(1) : r_rd;
    w_wr_nxt = w_push ? r_wr + PTR_W'(1) : r_wr;

    // The next head is the entry being written now when it lands on the new read slot.
    if (w_push && (r_wr == w_rd_nxt)) begin
      w_head_tag   = st_tag;
      w_head_flags = w_tflags;
    end else begin
      w_head_tag   = r_mem_tag[w_rd_nxt];
      w_head_flags = r_mem_flags[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fflags <= 5'b00000;
      r_vld    <= 1'b0;
      r_tag    <= '0;
      r_flags  <= 5'b00000;
      r_cnt    <= '0;
      r_lost   <= 1'b0;
      r_rd     <= '0;
      r_wr     <= '0;
    end else begin
      r_fflags <= w_fflags_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd     <= w_rd_nxt;
      r_wr     <= w_wr_nxt;
      r_vld    <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        r_tag   <= w_head_tag;
        r_flags <= w_head_flags;
      end else begin
        r_tag   <= '0;
        r_flags <= 5'b00000;
      end
      if (w_drop)
        r_lost <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_tag[r_wr]   <= st_tag;
      r_mem_flags[r_wr] <= w_tflags;
    end
  end

  assign fflags     = r_fflags;
  assign trap_vld   = r_vld;
  assign trap_tag   = r_tag;
  assign trap_flags = r_flags;
  assign trap_cnt   = r_cnt;
  assign trap_lost  = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_mul_flag_collect.sv
// Directed self-checking bench for mul_flag_collect (TAG_W=4, DEPTH=4).
`default_nettype none

module tb_mul_flag_collect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st_vld;
  logic       st_rdy;
  logic [4:0] status;
  logic [3:0] st_tag;
  logic       csr_wr;
  logic [4:0] csr_wdata;
  logic       csr_clr;
  logic [4:0] trap_en;
  logic [4:0] fflags;
  logic       trap_vld;
  logic       trap_rdy;
  logic [3:0] trap_tag;
  logic [4:0] trap_flags;
  logic [2:0] trap_cnt;
  logic       trap_lost;

  int checks = 0;
  int errors = 0;

  mul_flag_collect #(.TAG_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .st_vld(st_vld), .st_rdy(st_rdy),
    .status(status), .st_tag(st_tag), .csr_wr(csr_wr), .csr_wdata(csr_wdata),
    .csr_clr(csr_clr), .trap_en(trap_en), .fflags(fflags), .trap_vld(trap_vld),
    .trap_rdy(trap_rdy), .trap_tag(trap_tag), .trap_flags(trap_flags),
    .trap_cnt(trap_cnt), .trap_lost(trap_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_vld = 1'b0; status = 5'b0; st_tag = 4'd0;
    csr_wr = 1'b0; csr_clr = 1'b0; csr_wdata = 5'b0;
  endtask

  task automatic push(input logic [3:0] tag, input logic [4:0] st);
    st_vld = 1'b1; st_tag = tag; status = st;
  endtask

  task automatic head(input string name, input logic v, input logic [3:0] t,
                      input logic [4:0] f, input logic [2:0] c);
    chk({name, "_vld"},   32'(trap_vld),   32'(v));
    chk({name, "_tag"},   32'(trap_tag),   32'(t));
    chk({name, "_flags"}, 32'(trap_flags), 32'(f));
    chk({name, "_cnt"},   32'(trap_cnt),   32'(c));
  endtask

  initial begin
    rst_n = 1'b0; trap_rdy = 1'b0; trap_en = 5'b0;
    idle();
    tick();
    head("reset", 1'b0, 4'd0, 5'b0, 3'd0);
    chk("reset_fflags", 32'(fflags), 32'h0);
    chk("reset_lost",   32'(trap_lost), 32'h0);
    chk("st_rdy",       32'(st_rdy), 32'h1);
    rst_n = 1'b1;

    // basic accept, no trap enables
    push(4'd3, 5'b00001);
    tick();
    chk("basic_fflags", 32'(fflags), 32'b00001);
    head("basic", 1'b0, 4'd0, 5'b0, 3'd0);

    // clear, then sticky accumulation
    idle(); csr_clr = 1'b1;
    tick();
    chk("clr_fflags", 32'(fflags), 32'b00000);
    idle(); push(4'd0, 5'b00100);
    tick();
    push(4'd0, 5'b00010);
    tick();
    chk("sticky_fflags", 32'(fflags), 32'b00110);
    idle(); csr_clr = 1'b1; push(4'd0, 5'b10000);
    tick();
    chk("clr_collide", 32'(fflags), 32'b10000);
    idle();
    tick();
    chk("hold_fflags", 32'(fflags), 32'b10000);

    // CSR write collisions
    csr_wr = 1'b1; csr_wdata = 5'b00001; push(4'd0, 5'b01000);
    tick();
    chk("wr_collide", 32'(fflags), 32'b01001);
    idle(); csr_wr = 1'b1; csr_clr = 1'b1; csr_wdata = 5'b00110;
    tick();
    chk("wr_over_clr", 32'(fflags), 32'b00110);

    // trap queueing
    idle(); trap_en = 5'b10100; trap_rdy = 1'b0;
    push(4'd1, 5'b10000);
    tick();
    head("q1", 1'b1, 4'd1, 5'b10000, 3'd1);
    push(4'd2, 5'b00100); tick();
    push(4'd3, 5'b00011); tick();
    push(4'd4, 5'b10101); tick();
    idle();
    head("q3", 1'b1, 4'd1, 5'b10000, 3'd3);
    chk("q_fflags", 32'(fflags), 32'b10111);
    tick();
    head("q_stable", 1'b1, 4'd1, 5'b10000, 3'd3);
    trap_rdy = 1'b1;
    tick();
    head("pop1", 1'b1, 4'd2, 5'b00100, 3'd2);
    tick();
    head("pop2", 1'b1, 4'd4, 5'b10100, 3'd1);
    tick();
    head("pop3", 1'b0, 4'd0, 5'b0, 3'd0);
    tick();
    head("empty_rdy", 1'b0, 4'd0, 5'b0, 3'd0);

    // single entry replaced by simultaneous push and pop
    trap_rdy = 1'b0; push(4'd5, 5'b10000);
    tick();
    head("one", 1'b1, 4'd5, 5'b10000, 3'd1);
    trap_rdy = 1'b1; push(4'd6, 5'b00100);
    tick();
    head("replace", 1'b1, 4'd6, 5'b00100, 3'd1);
    idle();
    tick();
    head("drain", 1'b0, 4'd0, 5'b0, 3'd0);

    // overflow
    trap_rdy = 1'b0;
    push(4'd7, 5'b10000);  tick();
    push(4'd8, 5'b10000);  tick();
    push(4'd9, 5'b10000);  tick();
    push(4'd10, 5'b10000); tick();
    head("full", 1'b1, 4'd7, 5'b10000, 3'd4);
    chk("full_lost", 32'(trap_lost), 32'h0);
    csr_clr = 1'b1; push(4'd11, 5'b10000);
    tick();
    head("ovf", 1'b1, 4'd7, 5'b10000, 3'd4);
    chk("ovf_lost",   32'(trap_lost), 32'h1);
    chk("ovf_fflags", 32'(fflags), 32'b10000);
    idle(); trap_rdy = 1'b1; push(4'd11, 5'b10000);
    tick();
    head("full_pp", 1'b1, 4'd8, 5'b10000, 3'd4);
    chk("full_pp_lost", 32'(trap_lost), 32'h1);

    // reset mid-operation
    idle(); csr_wr = 1'b1; csr_wdata = 5'b11111;
    tick();
    idle(); trap_rdy = 1'b0;
    head("pre_rst", 1'b1, 4'd9, 5'b10000, 3'd3);
    chk("pre_rst_fflags", 32'(fflags), 32'b11111);
    rst_n = 1'b0;
    tick();
    head("mid_rst", 1'b0, 4'd0, 5'b0, 3'd0);
    chk("mid_rst_fflags", 32'(fflags), 32'h0);
    chk("mid_rst_lost",   32'(trap_lost), 32'h0);
    rst_n = 1'b1;
    push(4'd12, 5'b00100);
    tick();
    head("post_rst", 1'b1, 4'd12, 5'b00100, 3'd1);
    chk("post_rst_fflags", 32'(fflags), 32'b00100);
    push(4'd13, 5'b10000);
    tick();
    idle();
    head("post_rst2", 1'b1, 4'd12, 5'b00100, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
